// File: rtl/vector_reg_file.sv
// Vector register file: NREGS x N lanes x BITS, masked parallel write, two registered read ports,
// and a lane-serial load engine. Define READ_BYPASS_EN for write-first read forwarding.
module vector_reg_file #(
  parameter  int BITS  = 8,
  parameter  int N     = 64,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [N-1:0]    wr_mask,
  input  logic [BITS-1:0] wr_data [N-1:0],
  input  logic            rda_en,
  input  logic [AW-1:0]   rda_addr,
  output logic [BITS-1:0] rda_data [N-1:0],
  output logic            rda_valid,
  input  logic            rdb_en,
  input  logic [AW-1:0]   rdb_addr,
  output logic [BITS-1:0] rdb_data [N-1:0],
  output logic            rdb_valid,
  input  logic            ld_start,
  input  logic [AW-1:0]   ld_addr,
  input  logic            ld_valid,
  input  logic [BITS-1:0] ld_data,
  output logic            ld_ready,
  output logic            ld_done,
  output logic            busy
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   tgt;
  logic [CW-1:0]   cnt;
  logic            ld_acc;
  logic            ld_last;
  logic [BITS-1:0] mem      [NREGS-1:0][N-1:0];
  logic [BITS-1:0] rda_next [N-1:0];
  logic [BITS-1:0] rdb_next [N-1:0];

  assign busy     = (state_q == LOAD);
  assign ld_ready = (state_q == LOAD);
  assign ld_acc   = (state_q == LOAD) && ld_valid;
  assign ld_last  = (cnt == CW'(N-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld_start) state_d = LOAD;
      LOAD:    if (ld_acc && ld_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt     <= '0;
      cnt     <= '0;
      ld_done <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      if (state_q == IDLE && ld_start) begin
        tgt <= ld_addr;
        cnt <= '0;
      end else if (ld_acc) begin
        if (ld_last) begin
          cnt     <= '0;
          ld_done <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  // Parallel write is applied after the serial element so it wins a same-lane collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++)
        for (int unsigned i = 0; i < N; i++)
          mem[r][i] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++)
        for (int unsigned i = 0; i < N; i++) begin
          if (ld_acc && tgt == AW'(r) && cnt == CW'(i))
            mem[r][i] <= ld_data;
          if (wr_en && wr_addr == AW'(r) && wr_mask[i])
            mem[r][i] <= wr_data[i];
        end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      rda_next[i] = mem[rda_addr][i];
      rdb_next[i] = mem[rdb_addr][i];
`ifdef READ_BYPASS_EN
      if (ld_acc && rda_addr == tgt && cnt == CW'(i)) rda_next[i] = ld_data;
      if (ld_acc && rdb_addr == tgt && cnt == CW'(i)) rdb_next[i] = ld_data;
      if (wr_en && rda_addr == wr_addr && wr_mask[i]) rda_next[i] = wr_data[i];
      if (wr_en && rdb_addr == wr_addr && wr_mask[i]) rdb_next[i] = wr_data[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        rda_data[i] <= '0;
        rdb_data[i] <= '0;
      end
      rda_valid <= 1'b0;
      rdb_valid <= 1'b0;
    end else begin
      rda_valid <= rda_en;
      rdb_valid <= rdb_en;
      if (rda_en) rda_data <= rda_next;
      if (rdb_en) rdb_data <= rdb_next;
    end
  end

endmodule

// File: tb/tb_vector_reg_file.sv
// Directed self-checking bench for vector_reg_file (default parameters, optional READ_BYPASS_EN).
module tb_vector_reg_file;

  localparam int BITS = 8;
  localparam int N    = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [1:0]      wr_addr;
  logic [N-1:0]    wr_mask;
  logic [BITS-1:0] wr_data [N-1:0];
  logic            rda_en, rdb_en;
  logic [1:0]      rda_addr, rdb_addr;
  logic [BITS-1:0] rda_data [N-1:0];
  logic [BITS-1:0] rdb_data [N-1:0];
  logic            rda_valid, rdb_valid;
  logic            ld_start;
  logic [1:0]      ld_addr;
  logic            ld_valid;
  logic [BITS-1:0] ld_data;
  logic            ld_ready, ld_done, busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  vector_reg_file #(.BITS(BITS), .N(N), .NREGS(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rda_en(rda_en), .rda_addr(rda_addr), .rda_data(rda_data), .rda_valid(rda_valid),
    .rdb_en(rdb_en), .rdb_addr(rdb_addr), .rdb_data(rdb_data), .rdb_valid(rdb_valid),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_wr(input logic [BITS-1:0] v);
    for (int i = 0; i < N; i++) wr_data[i] = v;
  endtask

  task automatic read_a(input logic [1:0] a);
    rda_en = 1'b1; rda_addr = a;
    tick();
    rda_en = 1'b0;
  endtask

  int  k;
  int  dones;
  logic acc;
  logic [BITS-1:0] exp_l;

  initial begin
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_mask = '0; fill_wr(8'h00);
    rda_en = 0; rda_addr = 0; rdb_en = 0; rdb_addr = 0;
    ld_start = 0; ld_addr = 0; ld_valid = 0; ld_data = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_done", ld_done, 0);
    check("rst_rva", rda_valid, 0);
    check("rst_rda0", rda_data[0], 0);
    @(negedge clk); rst = 1'b0;
    tick();

    // masked write to reg 2, lanes 0 and 2
    wr_en = 1; wr_addr = 2; wr_mask = 64'h5; fill_wr(8'hAA);
    tick();
    wr_en = 0;
    read_a(2);
    check("mw_valid", rda_valid, 1);
    check("mw_l0", rda_data[0], 8'hAA);
    check("mw_l1", rda_data[1], 8'h00);
    check("mw_l2", rda_data[2], 8'hAA);
    check("mw_l3", rda_data[3], 8'h00);
    check("mw_l63", rda_data[63], 8'h00);
    tick();
    check("mw_valid_drop", rda_valid, 0);
    check("mw_hold", rda_data[0], 8'hAA);

    // write and read same register on the same edge
    wr_en = 1; wr_addr = 2; wr_mask = 64'h2; fill_wr(8'h11);
    rda_en = 1; rda_addr = 2;
    tick();
    wr_en = 0; rda_en = 0;
`ifdef READ_BYPASS_EN
    check("sameedge_l1", rda_data[1], 8'h11);
`else
    check("sameedge_l1", rda_data[1], 8'h00);
`endif
    check("sameedge_l0", rda_data[0], 8'hAA);
    rda_en = 1; rda_addr = 2; rdb_en = 1; rdb_addr = 2;
    tick();
    rda_en = 0; rdb_en = 0;
    check("after_l1", rda_data[1], 8'h11);
    check("portb_valid", rdb_valid, 1);
    check("portb_l0", rdb_data[0], 8'hAA);
    check("portb_l1", rdb_data[1], 8'h11);

    // serial load of reg 1 with ld_valid toggling, collision on lane 5
    ld_start = 1; ld_addr = 1;
    tick();
    check("ld_busy", busy, 1);
    check("ld_ready", ld_ready, 1);
    ld_addr = 3;  // ld_start held high during LOAD must be ignored
    k = 0; dones = 0;
    for (int cyc = 0; cyc < 400 && k < N; cyc++) begin
      ld_valid = (cyc % 2 == 0);
      ld_data  = BITS'(k);
      acc = ld_valid && ld_ready;
      if (acc && k == 5) begin
        wr_en = 1; wr_addr = 1; wr_mask = 64'h20; fill_wr(8'h55);
      end
      tick();
      wr_en = 0;
      if (ld_done) dones++;
      if (acc) k++;
      if (k == N) begin
        ld_start = 0;
        check("ld_done_pulse", ld_done, 1);
        check("ld_busy_low", busy, 0);
      end
    end
    ld_valid = 0; ld_start = 0;
    check("ld_accepts", k, N);
    check("ld_dones_in_load", dones, 1);
    tick();
    check("ld_done_1cyc", ld_done, 0);
    check("ld_idle", busy, 0);
    read_a(1);
    for (int i = 0; i < N; i++) begin
      exp_l = (i == 5) ? 8'h55 : BITS'(i);
      check($sformatf("ld_lane%0d", i), rda_data[i], exp_l);
    end
    read_a(3);
    check("ld_ignored_reg3", rda_data[0], 8'h00);

    // reset in the middle of a load of reg 1
    ld_start = 1; ld_addr = 1;
    tick();
    ld_start = 0; ld_valid = 1; ld_data = 8'hF0;
    for (int i = 0; i < 30; i++) tick();
    ld_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", ld_ready, 0);
    check("mid_rst_done", ld_done, 0);
    check("mid_rst_rda", rda_data[0], 8'h00);
    @(negedge clk); rst = 1'b0;
    tick();
    check("post_rst_done", ld_done, 0);
    read_a(1);
    check("clr_reg1_l0", rda_data[0], 8'h00);
    check("clr_reg1_l5", rda_data[5], 8'h00);
    read_a(2);
    check("clr_reg2_l0", rda_data[0], 8'h00);
    check("clr_reg2_l1", rda_data[1], 8'h00);

    // a new load restarts at lane 0
    ld_start = 1; ld_addr = 0;
    tick();
    ld_start = 0; ld_valid = 1; ld_data = 8'h07;
    tick();
    ld_valid = 0;
    read_a(0);
    check("restart_l0", rda_data[0], 8'h07);
    check("restart_l1", rda_data[1], 8'h00);
    check("restart_busy", busy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
